// File: rtl/ahb_apb_pkg.sv
// Shared APB completer types: bus phase encoding, violation codes and a
// small helper to detect more than one active slave select.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    NO_SETUP   = 3'd1,
    EXT_ACCESS = 3'd2,
    ADDR_CHG   = 3'd3,
    SETUP_DROP = 3'd4,
    MULTI_SEL  = 3'd5
  } apb_err_e;

  localparam int unsigned PSEL_W = 3;

  // True when two or more select lines are high at once.
  function automatic logic multi_hot(input logic [PSEL_W-1:0] sel_vec);
    return (sel_vec & (sel_vec - {{(PSEL_W-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// Word storage for the APB completer: one synchronous write port and one
// combinational read port whose output the parent captures in a register.
module apb_slv_mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Commit one word per edge; contents survive reset on purpose.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_responder.sv
// APB completer for the far end of the bridge: decodes a word window at
// BASE_ADDR, serves reads/writes from a local array, tracks the SETUP/ACCESS
// handshake and records protocol violations plus access statistics.
module apb_slave_responder
  import ahb_apb_pkg::*;
#(
  parameter int          SEL_IDX   = 0,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] OOR_RDATA = 32'h0000_0000
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  input  logic        err_clr,
  output logic        prot_err,
  output logic [2:0]  err_code,
  output logic        oor_hit,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  // Registered state
  apb_phase_e    r_state;
  logic [31:0]   r_addr;
  logic          r_write;
  logic          r_in_range;
  logic [AW-1:0] r_index;
  logic [31:0]   r_prdata;
  logic          r_prot_err;
  logic [2:0]    r_err_code;
  logic          r_oor_hit;
  logic [15:0]   r_wr_count;
  logic [15:0]   r_rd_count;

  // Combinational decode and control
  logic          w_sel;
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic          w_match;
  logic [31:0]   w_rdata;
  apb_phase_e    w_state_next;
  apb_err_e      w_err;
  logic          w_we;
  logic          w_mem_we;
  logic          w_wr_inc;
  logic          w_rd_inc;
  logic          w_oor_set;
  logic          w_setup_latch;
  logic [31:0]   w_prdata_next;

  assign w_sel      = Pselx[SEL_IDX];
  assign w_offset   = Paddr - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN) && (w_offset[1:0] == 2'b00);
  assign w_index    = w_offset[AW+1:2];
  assign w_match    = (Paddr == r_addr) && (Pwrite == r_write);

  // A write landing on the same edge as reset must never reach the array.
  assign w_mem_we = w_we && !Preset;

  apb_slv_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (Pclk),
    .i_we    (w_mem_we),
    .i_waddr (r_index),
    .i_wdata (Pwdata),
    .i_raddr (w_index),
    .o_rdata (w_rdata)
  );

  // Phase register: reset returns the handshake tracker to IDLE.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next phase, commit strobes and violation classification for this edge.
  always_comb begin
    w_state_next  = r_state;
    w_err         = NONE;
    w_we          = 1'b0;
    w_wr_inc      = 1'b0;
    w_rd_inc      = 1'b0;
    w_oor_set     = 1'b0;
    w_setup_latch = 1'b0;
    w_prdata_next = r_prdata;

    if (w_sel) begin
      if (!Penable) begin
        // Setup from any phase; read data is fetched now so it is stable
        // for the whole access cycle that follows.
        w_state_next  = SETUP;
        w_setup_latch = 1'b1;
        if (!Pwrite) begin
          w_prdata_next = w_in_range ? w_rdata : OOR_RDATA;
        end
      end else begin
        case (r_state)
          SETUP: begin
            w_state_next = ACCESS;
            if (!r_in_range) begin
              w_oor_set = 1'b1;
            end
            if (!w_match) begin
              w_err = ADDR_CHG;
            end else if (r_write) begin
              if (r_in_range) begin
                w_we     = 1'b1;
                w_wr_inc = 1'b1;
              end
            end else begin
              w_rd_inc = 1'b1;
            end
          end
          ACCESS: begin
            // No wait states exist, so a second enable cycle is a fault.
            w_state_next = ACCESS;
            w_err        = EXT_ACCESS;
          end
          default: begin
            w_state_next = IDLE;
            w_err        = NO_SETUP;
          end
        endcase
      end
      // A handshake violation outranks a multi-select report on the same edge.
      if ((w_err == NONE) && multi_hot(Pselx)) begin
        w_err = MULTI_SEL;
      end
    end else begin
      w_state_next  = IDLE;
      w_prdata_next = '0;
      if (r_state == SETUP) begin
        w_err = SETUP_DROP;
      end
    end
  end

  // Setup-phase capture of address, direction and range decode.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_in_range <= 1'b0;
      r_index    <= '0;
    end else if (w_setup_latch) begin
      r_addr     <= Paddr;
      r_write    <= Pwrite;
      r_in_range <= w_in_range;
      r_index    <= w_index;
    end
  end

  // Read data register driving Prdata.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_prdata <= '0;
    end else begin
      r_prdata <= w_prdata_next;
    end
  end

  // Sticky status: clear wins over any event on the same edge, and only the
  // first violation after a clear is recorded in the code.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_prot_err <= 1'b0;
      r_err_code <= '0;
      r_oor_hit  <= 1'b0;
    end else if (err_clr) begin
      r_prot_err <= 1'b0;
      r_err_code <= '0;
      r_oor_hit  <= 1'b0;
    end else begin
      if (w_err != NONE) begin
        r_prot_err <= 1'b1;
        if (!r_prot_err) begin
          r_err_code <= w_err;
        end
      end
      if (w_oor_set) begin
        r_oor_hit <= 1'b1;
      end
    end
  end

  // Saturating completion counters, cleared only by reset.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_wr_inc && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_rd_inc && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign Prdata   = r_prdata;
  assign prot_err = r_prot_err;
  assign err_code = r_err_code;
  assign oor_hit  = r_oor_hit;
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Scoreboard bench for apb_slave_responder: transaction tasks update a
// transaction-level reference model and queue expected read data; a bus
// monitor pops the queue on every well-formed read access cycle.
module tb_apb_slave_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DEP  = 64;
  localparam logic [31:0] OOR  = 32'hBAD0_0BAD;

  logic        Pclk;
  logic        Preset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        err_clr;
  logic        prot_err;
  logic [2:0]  err_code;
  logic        oor_hit;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  apb_slave_responder #(
    .SEL_IDX   (0),
    .BASE_ADDR (BASE),
    .DEPTH     (DEP),
    .OOR_RDATA (OOR)
  ) dut (
    .Pclk     (Pclk),
    .Preset   (Preset),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .err_clr  (err_clr),
    .prot_err (prot_err),
    .err_code (err_code),
    .oor_hit  (oor_hit),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [DEP];
  int          mdl_wr, mdl_rd, mdl_code;
  bit          mdl_perr, mdl_oor;
  logic [31:0] rd_q[$];

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < DEP * 4) && (off % 4 == 0);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  function automatic bit is_multi(input logic [2:0] m);
    return $countones(m) > 1;
  endfunction

  task automatic mdl_err(input int code);
    if (!mdl_perr) mdl_code = code;
    mdl_perr = 1'b1;
  endtask

  task automatic mdl_reset();
    mdl_wr = 0; mdl_rd = 0; mdl_code = 0; mdl_perr = 0; mdl_oor = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".wr_count"}, {16'h0, wr_count}, 32'(mdl_wr));
    check({tag, ".rd_count"}, {16'h0, rd_count}, 32'(mdl_rd));
    check({tag, ".prot_err"}, {31'h0, prot_err}, {31'h0, mdl_perr});
    check({tag, ".err_code"}, {29'h0, err_code}, 32'(mdl_code));
    check({tag, ".oor_hit"},  {31'h0, oor_hit},  {31'h0, mdl_oor});
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  bit          prev_setup = 1'b0;
  bit          prev_write = 1'b0;
  logic [31:0] prev_addr  = '0;

  // A read access cycle directly after a matching setup must present data.
  always @(negedge Pclk) begin
    if (prev_setup && !prev_write && Pselx[0] && Penable && !Pwrite && (Paddr == prev_addr)) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %h with no expected entry", Prdata);
      end else begin
        check("rd_data", Prdata, rd_q.pop_front());
      end
    end
    prev_setup = Pselx[0] && !Penable && !Preset;
    prev_write = Pwrite;
    prev_addr  = Paddr;
  end

  // ---------------- transaction tasks ----------------
  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic bus_idle();
    Pselx = 3'b000; Penable = 1'b0;
    tick();
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    $display("[TB] WR  addr=%h data=%h sel=%b", a, d, m);
    Pselx = m; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    tick();
    if (is_multi(m)) mdl_err(5);
    Penable = 1'b1;
    tick();
    if (in_rng(a)) begin
      mdl_mem[idx_of(a)] = d;
      if (mdl_wr < 65535) mdl_wr++;
    end else begin
      mdl_oor = 1'b1;
    end
    if (is_multi(m)) mdl_err(5);
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [2:0] m);
    $display("[TB] RD  addr=%h sel=%b", a, m);
    Pselx = m; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    rd_q.push_back(in_rng(a) ? mdl_mem[idx_of(a)] : OOR);
    tick();
    if (is_multi(m)) mdl_err(5);
    Penable = 1'b1;
    tick();
    if (mdl_rd < 65535) mdl_rd++;
    if (!in_rng(a)) mdl_oor = 1'b1;
    if (is_multi(m)) mdl_err(5);
  endtask

  task automatic other_slave(input logic [31:0] a, input logic w);
    $display("[TB] OTH addr=%h wr=%0b", a, w);
    Pselx = 3'b010; Penable = 1'b0; Pwrite = w; Paddr = a; Pwdata = $urandom;
    tick();
    Penable = 1'b1;
    tick();
  endtask

  task automatic clear_err();
    $display("[TB] CLR");
    Pselx = 3'b000; Penable = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    mdl_perr = 0; mdl_code = 0; mdl_oor = 0;
  endtask

  task automatic no_setup(input logic [31:0] a);
    $display("[TB] ERR no_setup addr=%h", a);
    bus_idle();
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'(($urandom) & 1); Paddr = a;
    tick();
    mdl_err(1);
  endtask

  task automatic addr_chg(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] d);
    $display("[TB] ERR addr_chg %h -> %h data=%h", a1, a2, d);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = a1; Pwdata = d;
    tick();
    Penable = 1'b1; Paddr = a2;
    tick();
    mdl_err(3);
  endtask

  task automatic dir_chg(input logic [31:0] a, input logic [31:0] d);
    $display("[TB] ERR dir_chg addr=%h", a);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = a; Pwdata = d;
    tick();
    Penable = 1'b1; Pwrite = 1'b1;
    tick();
    mdl_err(3);
  endtask

  task automatic setup_drop(input logic [31:0] a);
    $display("[TB] ERR setup_drop addr=%h", a);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    tick();
    bus_idle();
    mdl_err(4);
  endtask

  function automatic logic [31:0] rnd_addr();
    return BASE + 32'($urandom_range(0, DEP - 1)) * 4;
  endfunction

  function automatic logic [31:0] rnd_oor_addr();
    logic [31:0] a;
    case ($urandom_range(0, 2))
      0:       a = BASE + DEP * 4 + 32'($urandom_range(0, 255)) * 4;
      1:       a = BASE + 32'($urandom_range(0, DEP - 1)) * 4 + 32'($urandom_range(1, 3));
      default: a = BASE - 32'($urandom_range(1, 64)) * 4;
    endcase
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d, prior;
    Preset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; err_clr = 1'b0;
    mdl_reset();
    repeat (3) tick();
    check("reset.Prdata", Prdata, 32'h0);
    check_status("reset");
    Preset = 1'b0;

    // Give every word a known value, then restart the statistics.
    for (int i = 0; i < DEP; i++) apb_write(BASE + 32'(i) * 4, $urandom, 3'b001);
    bus_idle();
    Preset = 1'b1; tick(); Preset = 1'b0;
    mdl_reset();
    check_status("after_preload");

    // Write then read back one word.
    apb_write(32'h8000_0010, 32'hA5A5_0001, 3'b001);
    apb_read(32'h8000_0010, 3'b001);
    check_status("t1");

    // Back-to-back burst.
    for (int i = 0; i < 4; i++) apb_write(BASE + 32'(i) * 4, 32'h10 + 32'(i), 3'b001);
    for (int i = 0; i < 4; i++) apb_read(BASE + 32'(i) * 4, 3'b001);
    check_status("t2");

    // Out-of-range read and write.
    apb_read(32'h8000_0100, 3'b001);
    check_status("t3a");
    apb_write(32'h8000_0100, 32'h5555_AAAA, 3'b001);
    apb_read(BASE, 3'b001);
    check_status("t3b");

    // First violation is kept until cleared.
    clear_err();
    no_setup(BASE + 8);
    check_status("t4a");
    addr_chg(BASE + 12, BASE + 16, 32'h1234_5678);
    check_status("t4b");
    clear_err();
    check_status("t4c");

    // Address changed between setup and access.
    addr_chg(32'h8000_0004, 32'h8000_0008, 32'hCAFE_F00D);
    check_status("t5");
    apb_read(32'h8000_0004, 3'b001);
    apb_read(32'h8000_0008, 3'b001);
    clear_err();

    // Clear has priority over an abandoned setup on the same edge.
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = BASE;
    tick();
    Pselx = 3'b000; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    mdl_perr = 0; mdl_code = 0; mdl_oor = 0;
    check_status("clr_prio");

    // Multi-select is flagged but the access still completes.
    apb_write(BASE + 40, 32'h0BAD_CAFE, 3'b101);
    apb_read(BASE + 40, 3'b011);
    check_status("multi_sel");
    clear_err();

    // Reset landing on a write's access edge aborts it.
    prior = mdl_mem[5];
    $display("[TB] RST during write addr=%h", BASE + 20);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 20; Pwdata = 32'hDEAD_BEEF;
    tick();
    Penable = 1'b1; Preset = 1'b1;
    tick();
    mdl_reset();
    check("t6.Prdata", Prdata, 32'h0);
    check_status("t6_in_reset");
    Preset = 1'b0; Pselx = 3'b000; Penable = 1'b0;
    tick();
    apb_read(BASE + 20, 3'b001);
    check("t6.model_prior", mdl_mem[5], prior);
    check_status("t6_after");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 15);
      a = rnd_addr();
      d = $urandom;
      if (op <= 4)       apb_write(a, d, 3'b001);
      else if (op <= 8)  apb_read(a, 3'b001);
      else if (op == 9)  apb_read(rnd_oor_addr(), 3'b001);
      else if (op == 10) apb_write(rnd_oor_addr(), d, 3'b001);
      else if (op == 11) other_slave(a, 1'($urandom & 1));
      else if (op == 12) bus_idle();
      else if (op == 13) begin
        case ($urandom_range(0, 4))
          0: no_setup(a);
          1: setup_drop(a);
          2: addr_chg(a, a ^ 32'h4, d);
          3: dir_chg(a, d);
          default: begin
            apb_read(a, 3'b001);
            tick();
            mdl_err(2);
          end
        endcase
      end
      else if (op == 14) begin
        if ($urandom & 1) apb_write(a, d, 3'b011);
        else              apb_read(a, 3'b111);
      end
      else clear_err();
      check_status("rand");
    end

    bus_idle();
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
